ex_stage_md: RTL

- Parametrised next-generation execute stage for the RV32 pipeline.
- Resolves the full branch set (BEQ/BNE/BLT/BGE/BLTU/BGEU) from funct3, plus JAL/JALR.
- Widens ALU control to 4 bits.
- Adds an iterative M-extension multiply/divide unit whose FSM stalls the pipeline until the result is ready.

---
 rtl/ex_stage_md.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage_md.sv
// RV32 execute stage: ALU, full branch resolution, JAL/JALR,
// plus an iterative shift-add / restoring M-extension unit.
module ex_stage_md #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            FlushE_i,
  input  logic            ValidE_i,
  input  logic            MDOpE_i,
  input  logic [2:0]      MDFunct3E_i,
  input  logic [3:0]      ALUControlE_i,
  input  logic            ALUSrcE_i,
  input  logic            BranchE_i,
  input  logic [2:0]      BrFunct3E_i,
  input  logic [1:0]      JumpE_i,
  input  logic [XLEN-1:0] RD1E_i,
  input  logic [XLEN-1:0] RD2E_i,
  input  logic [XLEN-1:0] PCE_i,
  input  logic [XLEN-1:0] ImmExtE_i,
  output logic [XLEN-1:0] PCTargetE_o,
  output logic [XLEN-1:0] WriteDataE_o,
  output logic [XLEN-1:0] ALUResultE_o,
  output logic [1:0]      PCSrcE_o,
  output logic            StallE_o,
  output logic            MDBusyE_o
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE
  } md_state_e;

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2:0]        op_q, op_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;

  logic [XLEN-1:0] src_b, alu_res, jalr_sum, md_res;
  logic [SW-1:0]   shamt;
  logic            br_take, start;

  assign src_b        = ALUSrcE_i ? ImmExtE_i : RD2E_i;
  assign shamt        = src_b[SW-1:0];
  assign jalr_sum     = RD1E_i + ImmExtE_i;
  assign PCTargetE_o  = PCE_i + ImmExtE_i;
  assign WriteDataE_o = RD2E_i;
  assign start        = ValidE_i & MDOpE_i & ~FlushE_i;

  // combinational ALU
  always_comb begin
    alu_res = '0;
    case (ALUControlE_i)
      4'b0000: alu_res = RD1E_i + src_b;
      4'b0001: alu_res = RD1E_i - src_b;
      4'b0010: alu_res = RD1E_i & src_b;
      4'b0011: alu_res = RD1E_i | src_b;
      4'b0100: alu_res = RD1E_i ^ src_b;
      4'b0101: alu_res = {{(XLEN-1){1'b0}},
                          $signed(RD1E_i) < $signed(src_b)};
      4'b0110: alu_res = {{(XLEN-1){1'b0}}, RD1E_i < src_b};
      4'b0111: alu_res = RD1E_i << shamt;
      4'b1000: alu_res = RD1E_i >> shamt;
      4'b1001: alu_res = $unsigned($signed(RD1E_i) >>> shamt);
      4'b1010: alu_res = src_b;
      default: alu_res = '0;
    endcase
  end

  // branch condition and next-PC select
  always_comb begin
    br_take = 1'b0;
    case (BrFunct3E_i)
      3'b000:  br_take = RD1E_i == RD2E_i;
      3'b001:  br_take = RD1E_i != RD2E_i;
      3'b100:  br_take = $signed(RD1E_i) < $signed(RD2E_i);
      3'b101:  br_take = $signed(RD1E_i) >= $signed(RD2E_i);
      3'b110:  br_take = RD1E_i < RD2E_i;
      3'b111:  br_take = RD1E_i >= RD2E_i;
      default: br_take = 1'b0;
    endcase
    PCSrcE_o = 2'b00;
    if (!ValidE_i || MDOpE_i)   PCSrcE_o = 2'b00;
    else if (JumpE_i == 2'b01)  PCSrcE_o = 2'b01;
    else if (JumpE_i == 2'b10)  PCSrcE_o = 2'b10;
    else if (BranchE_i && br_take) PCSrcE_o = 2'b01;
  end

  logic            s1, s2, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_rsh, div_diff;
  logic [XLEN-1:0] div_rem;
  logic            div_ge;
  logic [2*XLEN-1:0] mul_nxt, div_nxt;

  // operand conditioning and one iteration of each datapath
  always_comb begin
    s1 = (MDFunct3E_i != 3'b011) & ~(MDFunct3E_i[2] & MDFunct3E_i[0]);
    s2 = s1 & (MDFunct3E_i != 3'b010);
    a_neg = s1 & RD1E_i[XLEN-1];
    b_neg = s2 & RD2E_i[XLEN-1];
    a_mag = a_neg ? -RD1E_i : RD1E_i;
    b_mag = b_neg ? -RD2E_i : RD2E_i;
    div0  = RD2E_i == '0;
    ovf   = ~MDFunct3E_i[0] & (RD1E_i == MIN) & (RD2E_i == '1);
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
            + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
    div_rsh  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_rsh - {1'b0, opa_q};
    div_ge   = ~div_diff[XLEN];
    div_rem  = div_ge ? div_diff[XLEN-1:0] : div_rsh[XLEN-1:0];
    div_nxt  = {div_rem, acc_q[XLEN-2:0], div_ge};
  end

  // M-unit next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    if (state_q != S_IDLE && FlushE_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          op_d  = MDFunct3E_i;
          cnt_d = '0;
          if (!MDFunct3E_i[2]) begin
            state_d = S_MUL;
            opa_d   = a_mag;
            acc_d   = {{XLEN{1'b0}}, b_mag};
            negq_d  = a_neg ^ b_neg;
            negr_d  = 1'b0;
          end else if (div0 || ovf) begin
            state_d = S_DONE;
            acc_d   = div0 ? {RD1E_i, {XLEN{1'b1}}}
                           : {{XLEN{1'b0}}, MIN};
            negq_d  = 1'b0;
            negr_d  = 1'b0;
          end else begin
            state_d = S_DIV;
            opa_d   = b_mag;
            acc_d   = {{XLEN{1'b0}}, a_mag};
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
          end
        end
        S_MUL, S_DIV: begin
          acc_d = (state_q == S_MUL) ? mul_nxt : div_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) state_d = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
      endcase
    end
  end

  // M-unit state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  // sign correction and result select
  always_comb begin
    prod = negq_q ? -acc_q : acc_q;
    quo  = negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                md_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: md_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        md_res = quo;
      default:               md_res = rem;
    endcase
    if (state_q == S_DONE && !FlushE_i) ALUResultE_o = md_res;
    else if (JumpE_i == 2'b10) ALUResultE_o = {jalr_sum[XLEN-1:1], 1'b0};
    else ALUResultE_o = alu_res;
  end

  assign StallE_o  = (state_q == S_IDLE & start)
                   | (state_q == S_MUL) | (state_q == S_DIV);
  assign MDBusyE_o = state_q != S_IDLE;

endmodule
